// File: rtl/multichannel_sample_history.sv
// Per-channel circular sample history with fill tracking, full policy, clear and overflow status.
// Reads return the state as it was before any write or clear in the same cycle, one cycle later.
module multichannel_sample_history #(
  parameter int NUM_CHANNELS = 14,
  parameter int SAMPLE_WIDTH = 8,
  parameter int DEPTH        = 10,
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int AGE_W = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    drop_when_full,
  input  logic                    wr_valid,
  input  logic [CH_W-1:0]         wr_channel,
  input  logic [SAMPLE_WIDTH-1:0] wr_data,
  input  logic                    clr_valid,
  input  logic [CH_W-1:0]         clr_channel,
  input  logic                    rd_req,
  input  logic [CH_W-1:0]         rd_channel,
  input  logic [AGE_W-1:0]        rd_age,
  output logic                    rd_valid,
  output logic [SAMPLE_WIDTH-1:0] rd_data,
  output logic                    rd_err,
  output logic [NUM_CHANNELS-1:0] full,
  output logic [NUM_CHANNELS-1:0] overflow
);

  localparam logic [CH_W:0]      NUM_CH_L  = (CH_W+1)'(NUM_CHANNELS);
  localparam logic [AGE_W-1:0]   LAST_SLOT = AGE_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [AGE_W:0]     DEPTH_X   = (AGE_W+1)'(DEPTH);

  logic [SAMPLE_WIDTH-1:0] mem_q [NUM_CHANNELS][DEPTH];
  logic [AGE_W-1:0]        wp_q   [NUM_CHANNELS];
  logic [AGE_W-1:0]        wp_d   [NUM_CHANNELS];
  logic [CNT_W-1:0]        fill_q [NUM_CHANNELS];
  logic [CNT_W-1:0]        fill_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] overflow_q, overflow_d;
  logic [NUM_CHANNELS-1:0] full_q, full_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    rd_err_q, rd_err_d;
  logic [SAMPLE_WIDTH-1:0] rd_data_q, rd_data_d;

  logic            wr_ch_ok, clr_ch_ok, rd_ch_ok;
  logic            wr_ok, clr_ok, mem_we;
  logic [CH_W-1:0] wr_idx, clr_idx, rd_idx;
  logic [AGE_W:0]  rd_slot_x;
  logic [AGE_W-1:0] rd_slot;

  // Out-of-range channels are steered to index 0 so array accesses stay in bounds.
  always_comb begin
    wr_ch_ok  = ({1'b0, wr_channel}  < NUM_CH_L);
    clr_ch_ok = ({1'b0, clr_channel} < NUM_CH_L);
    rd_ch_ok  = ({1'b0, rd_channel}  < NUM_CH_L);
    wr_idx    = wr_ch_ok  ? wr_channel  : '0;
    clr_idx   = clr_ch_ok ? clr_channel : '0;
    rd_idx    = rd_ch_ok  ? rd_channel  : '0;
    wr_ok     = ena & wr_valid & wr_ch_ok;
    clr_ok    = ena & clr_valid & clr_ch_ok;
  end

  always_comb begin
    wp_d       = wp_q;
    fill_d     = fill_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;
    if (clr_ok) begin
      wp_d[clr_idx]       = '0;
      fill_d[clr_idx]     = '0;
      overflow_d[clr_idx] = 1'b0;
    end
    if (wr_ok && !(clr_ok && (clr_idx == wr_idx))) begin
      if ((fill_q[wr_idx] == FULL_CNT) && drop_when_full) begin
        overflow_d[wr_idx] = 1'b1;
      end else begin
        mem_we         = 1'b1;
        wp_d[wr_idx]   = (wp_q[wr_idx] == LAST_SLOT) ? '0 : wp_q[wr_idx] + 1'b1;
        fill_d[wr_idx] = (fill_q[wr_idx] == FULL_CNT) ? FULL_CNT : fill_q[wr_idx] + 1'b1;
      end
    end
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      full_d[c] = (fill_d[c] == FULL_CNT);
    end
  end

  // Slot of age a is (wp - 1 - a) mod DEPTH; computed one bit wider to avoid underflow.
  always_comb begin
    rd_slot_x = {1'b0, wp_q[rd_idx]} + DEPTH_X - (AGE_W+1)'(1) - {1'b0, rd_age};
    if (rd_slot_x >= DEPTH_X) begin
      rd_slot = AGE_W'(rd_slot_x - DEPTH_X);
    end else begin
      rd_slot = AGE_W'(rd_slot_x);
    end
    rd_valid_d = ena & rd_req;
    rd_err_d   = rd_err_q;
    rd_data_d  = rd_data_q;
    if (rd_valid_d) begin
      rd_err_d  = !rd_ch_ok || (CNT_W'(rd_age) >= fill_q[rd_idx]);
      rd_data_d = rd_err_d ? '0 : mem_q[rd_idx][rd_slot];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        wp_q[c]   <= '0;
        fill_q[c] <= '0;
      end
      overflow_q <= '0;
      full_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wp_q       <= wp_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
      full_q     <= full_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Sample storage carries no reset; fill counts gate every read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_idx][wp_q[wr_idx]] <= wr_data;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_err   = rd_err_q;
  assign full     = full_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_multichannel_sample_history.sv
// Directed bench for multichannel_sample_history with hand-computed expectations.
module tb_multichannel_sample_history;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       drop_when_full = 1'b0;
  logic       wr_valid = 1'b0;
  logic [3:0] wr_channel = '0;
  logic [7:0] wr_data = '0;
  logic       clr_valid = 1'b0;
  logic [3:0] clr_channel = '0;
  logic       rd_req = 1'b0;
  logic [3:0] rd_channel = '0;
  logic [3:0] rd_age = '0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_err;
  logic [13:0] full;
  logic [13:0] overflow;

  int checks = 0;
  int failures = 0;

  multichannel_sample_history #(
    .NUM_CHANNELS(14), .SAMPLE_WIDTH(8), .DEPTH(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .drop_when_full(drop_when_full),
    .wr_valid(wr_valid), .wr_channel(wr_channel), .wr_data(wr_data),
    .clr_valid(clr_valid), .clr_channel(clr_channel),
    .rd_req(rd_req), .rd_channel(rd_channel), .rd_age(rd_age),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int d);
    wr_valid = 1'b1; wr_channel = 4'(ch); wr_data = 8'(d);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic clr(input int ch);
    clr_valid = 1'b1; clr_channel = 4'(ch);
    tick();
    clr_valid = 1'b0;
  endtask

  task automatic rd_resp(input string tag, input int exp_data, input bit exp_err);
    chk({tag, ".valid"}, 32'(rd_valid), 32'd1);
    chk({tag, ".err"}, 32'(rd_err), 32'(exp_err));
    chk({tag, ".data"}, 32'(rd_data), 32'(exp_data));
  endtask

  task automatic rd_chk(input string tag, input int ch, input int age, input int exp_data,
                        input bit exp_err);
    rd_req = 1'b1; rd_channel = 4'(ch); rd_age = 4'(age);
    tick();
    rd_req = 1'b0;
    rd_resp(tag, exp_data, exp_err);
  endtask

  initial begin
    #22;
    chk("rst.full", 32'(full), 32'h0);
    chk("rst.ovf", 32'(overflow), 32'h0);
    chk("rst.rd_valid", 32'(rd_valid), 32'd0);
    chk("rst.rd_data", 32'(rd_data), 32'h0);
    chk("rst.rd_err", 32'(rd_err), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    rd_chk("t1.rd", 0, 0, 8'h00, 1'b1);
    chk("t1.full", 32'(full), 32'h0);
    tick();
    chk("t1.idle_valid", 32'(rd_valid), 32'd0);
    chk("t1.hold_err", 32'(rd_err), 32'd1);

    wr(3, 8'h11); wr(3, 8'h22); wr(3, 8'h33);
    rd_chk("t2.age0", 3, 0, 8'h33, 1'b0);
    rd_chk("t2.age2", 3, 2, 8'h11, 1'b0);
    rd_chk("t2.age3", 3, 3, 8'h00, 1'b1);
    chk("t2.full", 32'(full), 32'h0);

    drop_when_full = 1'b0;
    for (int i = 1; i <= 12; i++) wr(5, i);
    chk("t3.full", 32'(full), 32'h0020);
    rd_chk("t3.age0", 5, 0, 12, 1'b0);
    rd_chk("t3.age9", 5, 9, 3, 1'b0);
    chk("t3.ovf", 32'(overflow), 32'h0);

    clr(5);
    chk("t4.clr_full", 32'(full), 32'h0);
    drop_when_full = 1'b1;
    for (int i = 1; i <= 12; i++) wr(5, i);
    rd_chk("t4.age0", 5, 0, 10, 1'b0);
    rd_chk("t4.age9", 5, 9, 1, 1'b0);
    chk("t4.ovf", 32'(overflow), 32'h0020);
    chk("t4.full", 32'(full), 32'h0020);
    clr(5);
    chk("t4.clr_ovf", 32'(overflow), 32'h0);
    chk("t4.clr_full2", 32'(full), 32'h0);
    rd_chk("t4.after_clr", 5, 0, 8'h00, 1'b1);
    drop_when_full = 1'b0;

    wr(2, 8'h55);
    wr_valid = 1'b1; wr_channel = 4'd2; wr_data = 8'hAA;
    rd_req = 1'b1; rd_channel = 4'd2; rd_age = 4'd0;
    tick();
    wr_valid = 1'b0; rd_req = 1'b0;
    rd_resp("t5.same_cycle", 8'h55, 1'b0);
    rd_chk("t5.next", 2, 0, 8'hAA, 1'b0);
    rd_chk("t5.age1", 2, 1, 8'h55, 1'b0);
    clr_valid = 1'b1; clr_channel = 4'd2;
    wr_valid = 1'b1; wr_channel = 4'd2; wr_data = 8'h99;
    tick();
    clr_valid = 1'b0; wr_valid = 1'b0;
    rd_chk("t5.clr_wins", 2, 0, 8'h00, 1'b1);
    wr(2, 8'h66);
    clr_valid = 1'b1; clr_channel = 4'd2;
    wr_valid = 1'b1; wr_channel = 4'd4; wr_data = 8'h44;
    tick();
    clr_valid = 1'b0; wr_valid = 1'b0;
    rd_chk("t5.other_wr", 4, 0, 8'h44, 1'b0);
    rd_chk("t5.other_clr", 2, 0, 8'h00, 1'b1);

    wr(13, 8'h7F);
    wr_valid = 1'b1; wr_channel = 4'd14; wr_data = 8'hFF;
    rd_req = 1'b1; rd_channel = 4'd15; rd_age = 4'd0;
    tick();
    wr_valid = 1'b0; rd_req = 1'b0;
    rd_resp("t6.bad_ch", 8'h00, 1'b1);
    rd_chk("t6.ch13", 13, 0, 8'h7F, 1'b0);
    rd_chk("t6.ch13_age1", 13, 1, 8'h00, 1'b1);
    rd_chk("t6.age_big", 3, 12, 8'h00, 1'b1);

    ena = 1'b0;
    wr_valid = 1'b1; wr_channel = 4'd13; wr_data = 8'h01;
    clr_valid = 1'b1; clr_channel = 4'd3;
    rd_req = 1'b1; rd_channel = 4'd3; rd_age = 4'd0;
    tick();
    wr_valid = 1'b0; clr_valid = 1'b0; rd_req = 1'b0;
    ena = 1'b1;
    chk("ena0.rd_valid", 32'(rd_valid), 32'd0);
    chk("ena0.hold_err", 32'(rd_err), 32'd1);
    rd_chk("ena0.ch13", 13, 0, 8'h7F, 1'b0);
    rd_chk("ena0.ch3", 3, 0, 8'h33, 1'b0);

    drop_when_full = 1'b1;
    for (int i = 0; i <= 10; i++) wr(5, i);
    chk("rst2.pre_full", 32'(full), 32'h0020);
    chk("rst2.pre_ovf", 32'(overflow), 32'h0020);
    rd_req = 1'b1; rd_channel = 4'd5; rd_age = 4'd0;
    tick();
    rd_resp("rst2.pre_rd", 9, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst2.rd_valid", 32'(rd_valid), 32'd0);
    chk("rst2.full", 32'(full), 32'h0);
    chk("rst2.ovf", 32'(overflow), 32'h0);
    rd_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst2.no_resp", 32'(rd_valid), 32'd0);
    rd_chk("rst2.ch3_empty", 3, 0, 8'h00, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
